// File: rtl/pipeline_pkg.sv
// pipeline_pkg: definitions shared by the hazard controller and the EX mul/div unit.
//   hz_state_e     - hazard controller state (RUN / MULTI)
//   REG_ZERO       - architectural x0, never a real dependency
//   MULDIV_LAT_DEF - default EX occupancy of a multi-cycle op
package pipeline_pkg;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_MULTI = 1'b1
   } hz_state_e;

   localparam logic [4:0] REG_ZERO       = 5'd0;
   localparam int         MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_multi_timer.sv
// hazard_multi_timer: loadable down-counter with a "last cycle" flag.
// Used by the hazard controller to time a multi-cycle EX op and reusable
// by the EX stage itself.
// Ports:
//   clock, reset   - rising-edge clock, asynchronous active-low reset
//   load, load_val - load the counter (has priority over dec)
//   dec            - decrement by one, saturating at zero
//   cnt            - current count
//   last           - count is 1 or 0: this decrement finishes the interval
module hazard_multi_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q <= ONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for IF/ID -> ID -> ID/EX.
// Each cycle decides PC/IF-ID hold, ID/EX bubble and IF/ID flush for
// load-use stalls, taken branches resolved in EX and multi-cycle EX ops.
// Outputs are a combinational decode of state and inputs, forced to a
// safe hold/flush pattern while reset is low.
// Optional feature: define HAZARD_PERF_EN to build the 32-bit stall
// counter on stall_cycles; otherwise stall_cycles is constant zero.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   id_rs1/rs2, uses_*    - source registers of the instruction in ID
//   idex_memread, idex_rd - load flag / destination of instruction in EX
//   ex_multi_start        - first EX cycle of a mul/div
//   ex_branch_taken       - branch/jump resolved taken in EX
//   pc_write, if_id_write, id_ex_write - register load enables
//   if_id_flush, id_ex_bubble          - clear IF/ID, zero ID/EX control
//   stall_cycles          - cycles with pc_write low
//   dbg_state, dbg_cnt    - FSM state and multi-cycle count, for checkers
// Handshake note: there is no valid/ready pairing here; every output is a
// level-sensitive per-cycle command consumed at the next rising clock.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEF,
   parameter int CNT_W      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic             ex_multi_start,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic [31:0]      stall_cycles,
   output hz_state_e        dbg_state,
   output logic [CNT_W-1:0] dbg_cnt
);

   // MULTI covers the freeze cycles after the start cycle, so it lasts
   // MULDIV_LAT-2 cycles; for MULDIV_LAT==2 the start cycle alone suffices.
   localparam logic [CNT_W-1:0] START_CNT = CNT_W'(MULDIV_LAT - 2);

   hz_state_e state_q;
   hz_state_e state_d;

   logic timer_load;
   logic timer_dec;
   logic timer_last;
   logic load_use;
   logic pc_w, if_id_w, flush, id_ex_w, bubble;

   assign load_use = idex_memread && (idex_rd != REG_ZERO) &&
                     ((id_uses_rs1 && (idex_rd == id_rs1)) ||
                      (id_uses_rs2 && (idex_rd == id_rs2)));

   hazard_multi_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (timer_load),
      .load_val (START_CNT),
      .dec      (timer_dec),
      .cnt      (dbg_cnt),
      .last     (timer_last)
   );

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      pc_w       = 1'b1;
      if_id_w    = 1'b1;
      flush      = 1'b0;
      id_ex_w    = 1'b1;
      bubble     = 1'b0;
      case (state_q)
         HZ_RUN: begin
            if (ex_branch_taken) begin
               // Squash the wrong-path instructions in IF/ID and ID.
               flush  = 1'b1;
               bubble = 1'b1;
            end else if (ex_multi_start) begin
               pc_w       = 1'b0;
               if_id_w    = 1'b0;
               id_ex_w    = 1'b0;
               timer_load = 1'b1;
               if (START_CNT != '0) begin
                  state_d = HZ_MULTI;
               end
            end else if (load_use) begin
               pc_w    = 1'b0;
               if_id_w = 1'b0;
               bubble  = 1'b1;
            end
         end
         HZ_MULTI: begin
            pc_w      = 1'b0;
            if_id_w   = 1'b0;
            id_ex_w   = 1'b0;
            timer_dec = 1'b1;
            if (timer_last) begin
               state_d = HZ_RUN;
            end
         end
         default: state_d = HZ_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= HZ_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign pc_write     = reset & pc_w;
   assign if_id_write  = reset & if_id_w;
   assign id_ex_write  = reset & id_ex_w;
   assign if_id_flush  = ~reset | flush;
   assign id_ex_bubble = ~reset | bubble;
   assign dbg_state    = state_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = reset ? stall_cnt_q : 32'd0;
`else
   assign stall_cycles = 32'd0;
`endif

   // The EX stage is frozen during MULTI, so it cannot legally start
   // another op or resolve a branch.
   a_multi_quiet : assert property (@(posedge clock) disable iff (!reset)
      (state_q == HZ_MULTI) |-> !(ex_branch_taken || ex_multi_start));

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the IF/ID → ID → ID/EX datapath.
- Decides each cycle whether the PC and IF/ID hold, whether ID/EX loads a bubble, and whether younger stages flush.
- Handles three cases: load-use stalls, taken-branch flushes in EX, and multi-cycle EX operations (mul/div) that freeze the front end for a fixed latency.
- Sits beside the decode stage; drives write-enable and clear inputs of the PC, if_id and id_ex pipeline registers.

Parameters:
- MULDIV_LAT, 4, total EX-occupancy cycles of a multi-cycle op (legal 2..16).
- CNT_W, 4, width of the multi-cycle down-counter (must hold MULDIV_LAT-1).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of instruction in ID (instr[19:15]).
- id_rs2  in  5  rs2 field of instruction in ID (instr[24:20]).
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  5  destination of instruction in EX.
- ex_multi_start  in  1  multi-cycle op is in its first EX cycle.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID synchronous clear to NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_bubble  out  1  ID/EX loads zero control (wb/m/ex) instead of decode outputs.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- State register, async clear on reset low: RUN, MULTI. Counter cnt (CNT_W bits) clears to 0.
- Outputs are a combinational decode of state plus current inputs; zero added latency.
- While reset is low, outputs are forced: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, id_ex_bubble=1, stall_cycles=0.
- load_use = idex_memread & idex_rd!=0 & ((id_uses_rs1 & idex_rd==id_rs1) | (id_uses_rs2 & idex_rd==id_rs2)).
- RUN, priority highest first:
  - ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_bubble=1. Overrides load_use. Stay RUN.
  - ex_multi_start: pc_write=0, if_id_write=0, id_ex_write=0, id_ex_bubble=0. Next state MULTI, cnt<=MULDIV_LAT-2.
  - load_use: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1. Exactly one bubble; stay RUN.
  - else: all enables 1, flush=0, bubble=0.
- MULTI: pc_write=0, if_id_write=0, id_ex_write=0.
  - cnt decrements each cycle.
  - When cnt==0, next state is RUN and the front end resumes the following cycle.
  - ex_branch_taken and ex_multi_start are ignored in MULTI. A concurrent assertion flags either being high.
- Total front-end freeze for one multi-cycle op = MULDIV_LAT-1 cycles including the start cycle.
- Register x0 never causes a load-use stall.
- ex_multi_start and ex_branch_taken both high in RUN: branch wins; no MULTI entry.
- Reset mid-MULTI: immediate return to RUN; cnt=0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: stall_cycles is a 32-bit counter, cleared by reset, incremented every cycle pc_write==0 while reset is high. Wraps 0xFFFFFFFF→0.
- Undefined: stall_cycles tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package pipeline_pkg holds:
  - state enum HZ_RUN=1'b0, HZ_MULTI=1'b1;
  - REG_ZERO=5'd0;
  - default MULDIV_LAT constant (shared with the EX mul/div unit).
- One natural sub-module: hazard_multi_timer, holding the down-counter plus done flag and reused by the EX stage.
- Load-use compare stays inline.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, id_rs1=5, id_uses_rs1=1 → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle with idex_memread=0 → all enables 1.
- x0 filter: idex_memread=1, idex_rd=0, id_rs2=0, id_uses_rs2=1 → no stall, id_ex_bubble=0.
- Branch over load-use: ex_branch_taken=1 plus a load_use match → if_id_flush=1, id_ex_bubble=1, pc_write=1.
- Multi-cycle with MULDIV_LAT=4: pulse ex_multi_start → pc_write=0 for exactly 3 cycles (start, plus 2 in MULTI), then 1. Under HAZARD_PERF_EN, stall_cycles=3.
- Reset mid-op: assert reset low during MULTI cnt=1 → outputs forced immediately. After release, state RUN and pc_write=1 with no pending stall.
- Perf wrap (HAZARD_PERF_EN): force stall_cycles=0xFFFFFFFF, one stall cycle → 0x00000000.
